// File: rtl/rammodel_halt_ctrl.sv
// Halt/resume sequencer for a group of memory-model instances.
// Freezes DUT time, settles, drains the gates, and reverses on resume.
module rammodel_halt_ctrl #(
    parameter int N_MODELS      = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                halt,
    input  logic [N_MODELS-1:0] up,
    input  logic [N_MODELS-1:0] down,
    output logic [N_MODELS-1:0] pause,
    output logic [N_MODELS-1:0] up_req,
    output logic [N_MODELS-1:0] down_req,
    output logic                halted,
    output logic [2:0]          state,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSE  = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4,
        S_RESUME = 3'd5
    } state_e;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ST_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            all_up;
    logic            all_down;
    logic            timed;
    logic            counting;
    logic            exit_cond;
    logic            to_hit;
    logic            pause_d;
    logic            up_req_d;
    logic            down_req_d;
    logic            halted_d;

    assign all_up   = &up;
    assign all_down = &down;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
            pause       <= '1;
            up_req      <= '1;
            down_req    <= '0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_err <= timeout_err | to_hit;
            pause       <= {N_MODELS{pause_d}};
            up_req      <= {N_MODELS{up_req_d}};
            down_req    <= {N_MODELS{down_req_d}};
            halted      <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timed     = 1'b0;
        counting  = 1'b0;
        exit_cond = 1'b0;
        case (state_q)
            S_INIT: begin
                timed     = 1'b1;
                counting  = 1'b1;
                exit_cond = all_up;
                if (all_up) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                counting  = 1'b1;
                exit_cond = (cnt_q == ST_LAST);
                if (exit_cond) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                timed     = 1'b1;
                counting  = 1'b1;
                exit_cond = all_down;
                if (all_down) state_d = S_HALTED;
            end
            S_HALTED: begin
                if (!halt) state_d = S_RESUME;
            end
            S_RESUME: begin
                timed     = 1'b1;
                counting  = 1'b1;
                exit_cond = all_up;
                if (all_up) state_d = S_RUN;
            end
            default: state_d = S_INIT;
        endcase

        // Counter restarts on every transition and saturates rather than wraps.
        if (state_d != state_q)
            cnt_d = '0;
        else if (counting && !exit_cond && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        to_hit = timed && !exit_cond && (cnt_q == TO_LAST);
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        pause_d    = (state_d != S_RUN);
        up_req_d   = (state_d == S_INIT) || (state_d == S_RESUME);
        down_req_d = (state_d == S_DRAIN) || (state_d == S_HALTED);
        halted_d   = (state_d == S_HALTED);
    end

endmodule

// File: tb/tb_rammodel_halt_ctrl.sv
// Scoreboard bench for rammodel_halt_ctrl: directed stimulus pushes
// expected snapshots, a negedge monitor pops and compares them.
module tb_rammodel_halt_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       halt = 1'b0;
    logic [1:0] up = 2'b00;
    logic [1:0] down = 2'b00;
    logic [1:0] pause;
    logic [1:0] up_req;
    logic [1:0] down_req;
    logic       halted;
    logic [2:0] state;
    logic       timeout_err;

    rammodel_halt_ctrl #(
        .N_MODELS(2),
        .SETTLE_CYCLES(4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .halt(halt),
        .up(up),
        .down(down),
        .pause(pause),
        .up_req(up_req),
        .down_req(down_req),
        .halted(halted),
        .state(state),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [10:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   active = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [2:0] INIT = 3'd0, RUN = 3'd1, PAU = 3'd2;
    localparam logic [2:0] DRN = 3'd3, HLT = 3'd4, RES = 3'd5;

    // Expected snapshot: {state, pause, up_req, down_req, halted, timeout_err}
    function automatic logic [10:0] snap(logic [2:0] s, logic [1:0] p,
                                         logic [1:0] ur, logic [1:0] dr,
                                         logic h, logic t);
        return {s, p, ur, dr, h, t};
    endfunction

    task automatic push(int c, string n, logic [10:0] v);
        exp_t e;
        e.cyc = c;
        e.name = n;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic at(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (active) begin
            logic [10:0] got;
            got = {state, pause, up_req, down_req, halted, timeout_err};
            checks++;
            if ((up_req & down_req) != 2'b00) begin
                errors++;
                $display("FAIL excl cyc=%0d up_req=%b down_req=%b required no overlap",
                         cyc, up_req, down_req);
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (got !== e.v || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h required=%h (st,p,ur,dr,h,t)",
                             e.name, cyc, got, e.v);
                end
            end
        end
    end

    initial begin
        int b;
        int b2;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        up = 2'b11;
        b = cyc;
        b2 = b + 77;

        push(b,      "rst_vals",   snap(INIT, 2'b11, 2'b11, 2'b00, 0, 0));
        push(b + 1,  "init_run",   snap(RUN,  2'b00, 2'b00, 2'b00, 0, 0));
        push(b + 10, "run_idle",   snap(RUN,  2'b00, 2'b00, 2'b00, 0, 0));
        push(b + 11, "pause_first",snap(PAU,  2'b11, 2'b00, 2'b00, 0, 0));
        push(b + 14, "pause_last", snap(PAU,  2'b11, 2'b00, 2'b00, 0, 0));
        push(b + 15, "drain_in",   snap(DRN,  2'b11, 2'b00, 2'b11, 0, 0));
        push(b + 16, "drain_wait", snap(DRN,  2'b11, 2'b00, 2'b11, 0, 0));
        push(b + 17, "halted",     snap(HLT,  2'b11, 2'b00, 2'b11, 1, 0));
        push(b + 20, "halted_h",   snap(HLT,  2'b11, 2'b00, 2'b11, 1, 0));
        push(b + 21, "resume_in",  snap(RES,  2'b11, 2'b11, 2'b00, 0, 0));
        push(b + 23, "resume_wait",snap(RES,  2'b11, 2'b11, 2'b00, 0, 0));
        push(b + 24, "resume_run", snap(RUN,  2'b00, 2'b00, 2'b00, 0, 0));
        push(b + 31, "pulse_pause",snap(PAU,  2'b11, 2'b00, 2'b00, 0, 0));
        push(b + 34, "pulse_plast",snap(PAU,  2'b11, 2'b00, 2'b00, 0, 0));
        push(b + 35, "pulse_drain",snap(DRN,  2'b11, 2'b00, 2'b11, 0, 0));
        push(b + 36, "pulse_halt", snap(HLT,  2'b11, 2'b00, 2'b11, 1, 0));
        push(b + 37, "pulse_res",  snap(RES,  2'b11, 2'b11, 2'b00, 0, 0));
        push(b + 38, "pulse_run",  snap(RUN,  2'b00, 2'b00, 2'b00, 0, 0));
        push(b + 45, "to_drain",   snap(DRN,  2'b11, 2'b00, 2'b11, 0, 0));
        push(b + 60, "to_pre",     snap(DRN,  2'b11, 2'b00, 2'b11, 0, 0));
        push(b + 61, "to_drain_err",snap(DRN, 2'b11, 2'b00, 2'b11, 0, 1));
        push(b + 62, "to_still",   snap(DRN,  2'b11, 2'b00, 2'b11, 0, 1));
        push(b + 63, "to_halted",  snap(HLT,  2'b11, 2'b00, 2'b11, 1, 1));
        push(b + 67, "r2_run",     snap(RUN,  2'b00, 2'b00, 2'b00, 0, 1));
        push(b + 73, "r2_drain",   snap(DRN,  2'b11, 2'b00, 2'b11, 0, 1));
        push(b + 76, "mid_reset",  snap(INIT, 2'b11, 2'b11, 2'b00, 0, 0));
        push(b2 + 15,"init_pre",   snap(INIT, 2'b11, 2'b11, 2'b00, 0, 0));
        push(b2 + 16,"init_err",   snap(INIT, 2'b11, 2'b11, 2'b00, 0, 1));
        push(b2 + 21,"init_hold",  snap(INIT, 2'b11, 2'b11, 2'b00, 0, 1));
        push(b2 + 22,"init_late",  snap(RUN,  2'b00, 2'b00, 2'b00, 0, 1));

        active = 1'b1;

        at(b + 10); halt = 1'b1;
        at(b + 16); down = 2'b11;
        at(b + 18); up = 2'b00;
        at(b + 20); halt = 1'b0;
        at(b + 23); up = 2'b11;
        at(b + 30); halt = 1'b1;
        at(b + 31); halt = 1'b0;
        at(b + 40); halt = 1'b1; down = 2'b10;
        at(b + 62); down = 2'b11;
        at(b + 65); halt = 1'b0; down = 2'b00;
        at(b + 68); halt = 1'b1;
        at(b + 75); reset = 1'b1; halt = 1'b0; up = 2'b01;
        at(b2);     reset = 1'b0;
        at(b2 + 21); up = 2'b11;
        at(b2 + 25);

        if (q.size() != 0) begin
            errors += q.size();
            $display("FAIL pending entries=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rammodel_halt_ctrl.md
# rammodel_halt_ctrl

Sequencer that brings a group of N memory-model instances to a quiescent, drained state and back. Used around checkpoint, scan-out and host-side DRAM access. It drives each model's `pause`, `up_req` and `down_req`, and watches each model's `up` and `down` acknowledges. One host-level `halt` command is thus turned into a safe, ordered sequence: freeze DUT time, let in-flight handshakes settle, close and drain the transaction gates, report halted. Resume runs the reverse order. Sits between the emulator control/host interface and all memory-model instances.

## Interface
Parameters:
- `N_MODELS`, 2: number of memory-model instances controlled.
- `SETTLE_CYCLES`, 4: cycles held in PAUSE before gates are closed; minimum 1.
- `TIMEOUT`, 1024: wait-cycle limit in INIT/DRAIN/RESUME before `timeout_err` is flagged; minimum 1.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `halt` in 1: level command; 1 = target halted, 0 = target running.
- `up` in N_MODELS: per-model gate-open acknowledge, level.
- `down` in N_MODELS: per-model gate-closed-and-drained acknowledge, level.
- `pause` out N_MODELS: per-model DUT-time freeze.
- `up_req` out N_MODELS: per-model gate-open request, level.
- `down_req` out N_MODELS: per-model gate-close request, level.
- `halted` out 1: 1 exactly while in HALTED.
- `state` out 3: encoding INIT=0, RUN=1, PAUSE=2, DRAIN=3, HALTED=4, RESUME=5.
- `timeout_err` out 1: sticky; cleared only by `reset`.

## Operation
- All outputs are registered and decoded from the state register. All bits of `pause`, `up_req` and `down_req` always carry the same value. `up_req` and `down_req` are never both 1.
- `all_up` = AND of `up`; `all_down` = AND of `down`.
- INIT: pause=1, up_req=1, down_req=0. Go to RUN when `all_up`.
- RUN: pause=0, up_req=0, down_req=0. Go to PAUSE when `halt`=1.
- PAUSE: pause=1, up_req=0, down_req=0. Stays exactly SETTLE_CYCLES cycles, then goes to DRAIN. `halt` is ignored in this state.
- DRAIN: pause=1, down_req=1. Go to HALTED when `all_down`. A drop of `halt` here does not abort the sequence.
- HALTED: pause=1, down_req=1, halted=1. Go to RESUME when `halt`=0.
- RESUME: pause=1, down_req=0, up_req=1. Go to RUN when `all_up`. `halt` is ignored until RUN.
- Wait counter: width `$clog2(TIMEOUT+1)`. Cleared on every state change. Increments each cycle in INIT, DRAIN or RESUME while the exit condition is false; it saturates and does not wrap. When it equals TIMEOUT-1 with the exit condition still false, `timeout_err` is set on the next edge. The FSM keeps waiting and never forces a transition.
- PAUSE uses the same counter against SETTLE_CYCLES-1.
- Undefined state encodings go to INIT.

## Timing
- Reset values: state=INIT, pause=all 1, up_req=all 1, down_req=0, halted=0, timeout_err=0, counter=0.
- Reset asserted mid-sequence: next edge returns to INIT with the values above, regardless of current state.
- Cycle 0 = first cycle with `reset`=0. If `all_up` is sampled at cycle c, state=RUN and pause=0 at c+1.
- `halt` sampled 1 at cycle t in RUN: pause=1 at t+1. PAUSE occupies t+1..t+SETTLE_CYCLES. down_req=1 at t+SETTLE_CYCLES+1.
- `all_down` sampled at cycle d in DRAIN: halted=1 at d+1.
- `halt` sampled 0 at cycle h in HALTED: down_req=0 and up_req=1 at h+1. If `all_up` is sampled at u: pause=0 and up_req=0 at u+1.
- Exit condition already true on the first cycle of a wait state: leave one cycle later. Every wait state therefore lasts at least one cycle.
- Partial acknowledges (some models up or down, others not) do not satisfy the exit condition.

## Test plan
Bench settings: N_MODELS=2, SETTLE_CYCLES=4, TIMEOUT=16.
- Reset release with up=2'b11 at cycle 0 -> state=RUN and pause=2'b00 at cycle 1; with up=2'b01 held, state stays INIT and timeout_err=1 at cycle 16.
- RUN, halt rises at t=10, down=2'b11 from t=16 -> pause=2'b11 at 11, state=PAUSE at 11..14, down_req=2'b11 at 15, halted=1 at 17.
- In DRAIN, down=2'b10 held -> no HALTED, timeout_err=1 exactly 16 cycles after DRAIN entry. Then down=2'b11 -> HALTED next cycle; timeout_err stays 1.
- HALTED, halt falls at h, up=2'b11 at h+3 -> up_req=2'b11 and down_req=0 at h+1, pause=0 and state=RUN at h+4.
- halt pulses high for 1 cycle in RUN -> full sequence runs to HALTED, then immediately to RESUME and back to RUN. up_req and down_req never both 1 on any cycle.
- Reset asserted during DRAIN -> next cycle state=INIT, pause=2'b11, up_req=2'b11, down_req=0, timeout_err=0.
